// File: rtl/bitstream_word_loader_if.sv
// bitstream_word_loader_if: byte-stream valid/ready handshake feeding the loader.
//   byte_valid : upstream byte available (master -> slave)
//   byte_data  : bitstream byte, packed big-endian by the loader
//   byte_last  : marks the final byte of the stream
//   byte_ready : loader accepts a byte when byte_valid & byte_ready
interface bitstream_word_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);
endinterface

// File: rtl/bitstream_word_loader.sv
// bitstream_word_loader: packs a byte stream big-endian into 32-bit words and
// presents each one on SelfWriteData with a one-cycle SelfWriteStrobe, spaced
// by SETUP_CYCLES before and HOLD_CYCLES after the strobe.
// Ports:
//   CLK, reset      : clock, synchronous active-high reset
//   start           : one-cycle pulse starting a load (honoured in IDLE/DONE)
//   byte_if         : byte stream handshake (slave side)
//   SelfWriteData   : configuration word to the fabric
//   SelfWriteStrobe : one-cycle write strobe
//   busy/done/error : load in progress / sticky completion / sticky partial word
//   word_count      : words strobed in the current load (saturating)
// Build option: define BITSTREAM_LOADER_PAD_EN to zero-pad and strobe a partial
// final word; otherwise a partial final word is dropped and error is raised.
module bitstream_word_loader #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned MAX_BYTES    = 16384
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          start,
  bitstream_word_loader_if.slave        byte_if,
  output logic [31:0]                   SelfWriteData,
  output logic                          SelfWriteStrobe,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [15:0]                   word_count
);

  localparam int unsigned TMR_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned BC_W    = $clog2(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [23:0]       lane_buf;    // lanes 0..2 of the word being collected
  logic [BC_W-1:0]   byte_cnt;    // bytes accepted in this load (wraps only on the final byte)
  logic              final_word;
  logic [TMR_W-1:0]  tmr;

  logic accept_c;
  logic last_c;

  assign accept_c = byte_if.byte_valid & byte_if.byte_ready;
  // The MAX_BYTES-th byte ends the load exactly like byte_last.
  assign last_c   = byte_if.byte_last | (byte_cnt == BC_W'(MAX_BYTES - 1));

`ifdef BITSTREAM_LOADER_PAD_EN
  logic [31:0] pad_word_c;

  // Partial word with the unfilled low lanes zeroed.
  always_comb begin
    pad_word_c = '0;
    case (byte_idx)
      2'd0:    pad_word_c = {byte_if.byte_data, 24'h0};
      2'd1:    pad_word_c = {lane_buf[23:16], byte_if.byte_data, 16'h0};
      2'd2:    pad_word_c = {lane_buf[23:8], byte_if.byte_data, 8'h0};
      default: pad_word_c = {lane_buf, byte_if.byte_data};
    endcase
  end
`endif

  // Load sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state              <= S_IDLE;
      byte_idx           <= '0;
      lane_buf           <= '0;
      byte_cnt           <= '0;
      final_word         <= 1'b0;
      tmr                <= '0;
      SelfWriteData      <= '0;
      SelfWriteStrobe    <= 1'b0;
      byte_if.byte_ready <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      word_count         <= '0;
    end else begin
      SelfWriteStrobe <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done               <= 1'b0;
            error              <= 1'b0;
            word_count         <= '0;
            byte_cnt           <= '0;
            byte_idx           <= '0;
            final_word         <= 1'b0;
            busy               <= 1'b1;
            byte_if.byte_ready <= 1'b1;
            state              <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (accept_c) begin
            byte_cnt   <= byte_cnt + BC_W'(1);
            final_word <= last_c;
            if (byte_idx == 2'd3) begin
              SelfWriteData      <= {lane_buf, byte_if.byte_data};
              byte_idx           <= '0;
              byte_if.byte_ready <= 1'b0;
              tmr                <= TMR_W'(SETUP_CYCLES - 1);
              state              <= S_SETUP;
            end else if (last_c) begin
`ifdef BITSTREAM_LOADER_PAD_EN
              SelfWriteData      <= pad_word_c;
              byte_idx           <= '0;
              byte_if.byte_ready <= 1'b0;
              tmr                <= TMR_W'(SETUP_CYCLES - 1);
              state              <= S_SETUP;
`else
              error              <= 1'b1;
              done               <= 1'b1;
              busy               <= 1'b0;
              byte_if.byte_ready <= 1'b0;
              state              <= S_DONE;
`endif
            end else begin
              case (byte_idx)
                2'd0:    lane_buf[23:16] <= byte_if.byte_data;
                2'd1:    lane_buf[15:8]  <= byte_if.byte_data;
                default: lane_buf[7:0]   <= byte_if.byte_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_SETUP: begin
          if (tmr == '0) begin
            SelfWriteStrobe <= 1'b1;
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            state <= S_STROBE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_STROBE: begin
          tmr   <= TMR_W'(HOLD_CYCLES - 1);
          state <= S_HOLD;
        end

        S_HOLD: begin
          if (tmr == '0) begin
            if (final_word) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              byte_if.byte_ready <= 1'b1;
              state              <= S_COLLECT;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_word_loader.sv
// tb_bitstream_word_loader: directed and randomized loads checked against a
// stream-level reference model (bytes grouped four at a time, tail padded or
// dropped depending on BITSTREAM_LOADER_PAD_EN).
`timescale 1ns/1ps
module tb_bitstream_word_loader;
  localparam int unsigned S = 2;
  localparam int unsigned H = 2;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  bitstream_word_loader_if bif();
  bitstream_word_loader_if bif8();

  logic        start, start8;
  logic [31:0] wdata, wdata8;
  logic        strobe, strobe8;
  logic        busy, busy8, done, done8, error, error8;
  logic [15:0] wcnt, wcnt8;

  bitstream_word_loader #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .MAX_BYTES(16384)) dut (
    .CLK(CLK), .reset(reset), .start(start), .byte_if(bif),
    .SelfWriteData(wdata), .SelfWriteStrobe(strobe),
    .busy(busy), .done(done), .error(error), .word_count(wcnt)
  );

  bitstream_word_loader #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .MAX_BYTES(8)) dut8 (
    .CLK(CLK), .reset(reset), .start(start8), .byte_if(bif8),
    .SelfWriteData(wdata8), .SelfWriteStrobe(strobe8),
    .busy(busy8), .done(done8), .error(error8), .word_count(wcnt8)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Edge counter and monitors (sampled mid-cycle, away from the active edge).
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] strobe_q[$];
  int unsigned strobe_cyc[$];
  int unsigned acc_cyc[$];
  int unsigned done_rise_cyc = 0;
  logic        done_prev = 1'b0;
  int unsigned acc8 = 0;
  int unsigned str8 = 0;

  always @(negedge CLK) begin
    if (strobe) begin
      strobe_q.push_back(wdata);
      strobe_cyc.push_back(cyc);
    end
    if (bif.byte_valid && bif.byte_ready && !reset) acc_cyc.push_back(cyc + 1);
    if (done && !done_prev) done_rise_cyc = cyc;
    done_prev = done;
    if (bif8.byte_valid && bif8.byte_ready && !reset) acc8++;
    if (strobe8) str8++;
  end

  // Reference model state.
  logic [7:0]  sent_q[$];
  logic [31:0] exp_words[$];
  logic        exp_error;

  function automatic void model(input int unsigned maxb);
    int unsigned n, full, rem;
    logic [31:0] w;
    exp_words.delete();
    exp_error = 1'b0;
    n    = (sent_q.size() < maxb) ? sent_q.size() : maxb;
    full = n / 4;
    rem  = n % 4;
    for (int i = 0; i < int'(full); i++)
      exp_words.push_back({sent_q[4*i], sent_q[4*i+1], sent_q[4*i+2], sent_q[4*i+3]});
    if (rem != 0) begin
`ifdef BITSTREAM_LOADER_PAD_EN
      w = '0;
      for (int k = 0; k < int'(rem); k++) w[31-8*k -: 8] = sent_q[4*full+k];
      exp_words.push_back(w);
`else
      exp_error = 1'b1;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    strobe_q.delete();
    strobe_cyc.delete();
    acc_cyc.delete();
    sent_q.delete();
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_rdy"},  32'(bif.byte_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_wc"},   32'(wcnt), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int unsigned gap);
    int unsigned budget;
    for (int i = 0; i < int'(gap); i++) tick();
    bif.byte_valid = 1'b1;
    bif.byte_data  = d;
    bif.byte_last  = l;
    budget = 0;
    while (!bif.byte_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!bif.byte_ready) check("accept_timeout", 32'(bif.byte_ready), 32'd1);
    tick();
    sent_q.push_back(d);
    bif.byte_valid = 1'b0;
    bif.byte_last  = 1'b0;
    bif.byte_data  = 8'h00;
  endtask

  task automatic wait_done();
    int unsigned b = 0;
    while (!done && b < 400) begin
      tick();
      b++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    tick();
  endtask

  task automatic compare_load(input string tag);
    int unsigned n;
    model(16384);
    check({tag, "_nstrobe"}, 32'(strobe_q.size()), 32'(exp_words.size()));
    n = (strobe_q.size() < exp_words.size()) ? strobe_q.size() : exp_words.size();
    for (int i = 0; i < int'(n); i++) check({tag, "_word"}, strobe_q[i], exp_words[i]);
    check({tag, "_wc"},   32'(wcnt), 32'(exp_words.size()));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"},  32'(error), 32'(exp_error));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdy"},  32'(bif.byte_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat6 [6];
    int unsigned idx;
    logic got;
    int unsigned len, gap;

    reset = 1'b1;
    start = 1'b0;
    start8 = 1'b0;
    bif.byte_valid = 1'b0; bif.byte_data = 8'h00; bif.byte_last = 1'b0;
    bif8.byte_valid = 1'b0; bif8.byte_data = 8'h00; bif8.byte_last = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values.
    check("rst_data",   wdata, 32'h0);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_rdy",    32'(bif.byte_ready), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(error), 32'd0);
    check("rst_wc",     32'(wcnt), 32'd0);

    // Eight bytes back-to-back.
    clear_mon();
    do_start("t1_start");
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 0);
    wait_done();
    compare_load("t1");
    if (strobe_q.size() == 2) begin
      check("t1_w0", strobe_q[0], 32'h01020304);
      check("t1_w1", strobe_q[1], 32'h05060708);
      check("t1_period", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd9);
      check("t1_done_lat", 32'(done_rise_cyc - strobe_cyc[1]), 32'(1 + H));
    end
    if (acc_cyc.size() == 8 && strobe_cyc.size() >= 1) begin
      check("t1_setup_lat", 32'(strobe_cyc[0] - acc_cyc[3]), 32'(S));
      check("t1_reaccept",  32'(acc_cyc[4] - acc_cyc[3]), 32'(S + 1 + H + 1));
    end

    // Single word with gaps between bytes.
    clear_mon();
    do_start("t2_start");
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3, 3);
    wait_done();
    compare_load("t2");
    if (acc_cyc.size() == 4)
      check("t2_done_lat", 32'(done_rise_cyc - acc_cyc[3]), 32'(S + 1 + H));

    // Partial final word.
    clear_mon();
    pat6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    do_start("t3_start");
    for (int i = 0; i < 6; i++) send_byte(pat6[i], i == 5, 0);
    wait_done();
    compare_load("t3");
`ifdef BITSTREAM_LOADER_PAD_EN
    if (strobe_q.size() == 2) check("t3_pad", strobe_q[1], 32'hEEFF0000);
`else
    check("t3_err", 32'(error), 32'd1);
`endif

    // MAX_BYTES = 8 instance with 12 bytes offered and no byte_last.
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    idx = 0;
    bif8.byte_valid = 1'b1;
    bif8.byte_data  = 8'd1;
    for (int c = 0; c < 60; c++) begin
      got = bif8.byte_ready;
      tick();
      if (got && idx < 12) begin
        idx++;
        bif8.byte_data = 8'(idx + 1);
        if (idx == 12) bif8.byte_valid = 1'b0;
      end
    end
    bif8.byte_valid = 1'b0;
    check("max_acc",    32'(acc8), 32'd8);
    check("max_strobe", 32'(str8), 32'd2);
    check("max_done",   32'(done8), 32'd1);
    check("max_busy",   32'(busy8), 32'd0);
    check("max_rdy",    32'(bif8.byte_ready), 32'd0);
    check("max_err",    32'(error8), 32'd0);
    check("max_data",   wdata8, 32'h05060708);
    check("max_wc",     32'(wcnt8), 32'd2);

    // Reset during SETUP of word 2.
    clear_mon();
    do_start("t5_start");
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h30 + i), i == 8, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_data",   wdata, 32'h0);
    check("mid_rst_strobe", 32'(strobe), 32'd0);
    check("mid_rst_rdy",    32'(bif.byte_ready), 32'd0);
    check("mid_rst_busy",   32'(busy), 32'd0);
    check("mid_rst_done",   32'(done), 32'd0);
    check("mid_rst_wc",     32'(wcnt), 32'd0);
    repeat (10) tick();
    check("mid_rst_nstrobe", 32'(strobe_q.size()), 32'd1);
    clear_mon();
    do_start("t5_restart");
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    wait_done();
    compare_load("t5");

    // start pulses while busy are ignored.
    clear_mon();
    do_start("t6_start");
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'hC2, 1'b0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_rdy", 32'(bif.byte_ready), 32'd1);
    send_byte(8'hC3, 1'b0, 0);
    send_byte(8'hC4, 1'b0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 5; i <= 8; i++) send_byte(8'(8'hC0 + i), i == 8, 0);
    wait_done();
    compare_load("t6");

    // Randomized loads, each started from DONE.
    for (int r = 0; r < 8; r++) begin
      clear_mon();
      len = $urandom_range(1, 14);
      do_start("rnd_start");
      for (int i = 0; i < int'(len); i++) begin
        gap = $urandom_range(0, 3);
        send_byte(8'($urandom), i == int'(len) - 1, gap);
      end
      wait_done();
      compare_load("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
